// File: rtl/enemy_draw.sv
// enemy_draw
// -----------------------------------------------------------------------------
// Draws one enemy sprite on top of the VGA pixel stream. The enemy position
// and alive flag come from the position generator. They are captured once per
// frame, on the rising edge of vertical blanking. The sprite is WIDTH x HEIGHT
// texels. Texels come from an external single-cycle synchronous ROM, and any
// texel equal to TRANSPARENT lets the upstream colour through.
//
// Stream protocol: there is no valid/ready handshake. Every pclk cycle carries
// one pixel. Every output is the corresponding input delayed by exactly 3 pclk
// cycles. pixel_addr is issued 2 cycles ahead of the rgb_out it affects.
//
// Ports
//   pclk                      pixel clock, all state on rising edge
//   rst                       asynchronous active-low reset
//   x_in, y_in                enemy top-left corner (sampled at vblnk rise)
//   alive                     enemy drawn when 1 (sampled at vblnk rise)
//   hcount_in, vcount_in      pixel coordinates
//   hsync_in .. vblnk_in      VGA timing
//   rgb_in                    upstream colour
//   rgb_pixel                 ROM data, valid one cycle after pixel_addr
//   pixel_addr                registered ROM address {row, col}
//   hcount_out .. vblnk_out   timing and coordinates delayed 3 cycles
//   rgb_out                   composited colour
// -----------------------------------------------------------------------------
module enemy_draw #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HEIGHT      = 32,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic                                   pclk,
  input  logic                                   rst,
  input  logic [10:0]                            x_in,
  input  logic [10:0]                            y_in,
  input  logic                                   alive,
  input  logic [10:0]                            hcount_in,
  input  logic [10:0]                            vcount_in,
  input  logic                                   hsync_in,
  input  logic                                   vsync_in,
  input  logic                                   hblnk_in,
  input  logic                                   vblnk_in,
  input  logic [11:0]                            rgb_in,
  input  logic [11:0]                            rgb_pixel,
  output logic [$clog2(WIDTH)+$clog2(HEIGHT)-1:0] pixel_addr,
  output logic [10:0]                            hcount_out,
  output logic [10:0]                            vcount_out,
  output logic                                   hsync_out,
  output logic                                   vsync_out,
  output logic                                   hblnk_out,
  output logic                                   vblnk_out,
  output logic [11:0]                            rgb_out
);

  localparam int unsigned COL_W  = $clog2(WIDTH);
  localparam int unsigned ROW_W  = $clog2(HEIGHT);
  localparam int unsigned ADDR_W = COL_W + ROW_W;
  // {hcount, vcount, hsync, vsync, hblnk, vblnk}
  localparam int unsigned TIM_W  = 26;

  // Frame latch
  logic        vblnk_prev_q;
  logic [10:0] x_lat_q, y_lat_q;
  logic        alive_lat_q;
  logic        latch_d;

  // Stage 1
  logic              in_box_d, in_box_q1;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [TIM_W-1:0]  tim_d, tim_q1;
  logic [11:0]       rgb_q1;

  // Stage 2
  logic              in_box_q2;
  logic [TIM_W-1:0]  tim_q2;
  logic [11:0]       rgb_q2;

  // Stage 3
  logic [TIM_W-1:0]  tim_q3;
  logic [11:0]       rgb_d, rgb_q3;

  // Box bounds in 12 bits so a sprite near column/row 2047 clips at the
  // screen edge instead of wrapping back to 0.
  logic [11:0] x_end, y_end;
  logic        h_hit, v_hit;

  always_comb begin
    latch_d  = vblnk_in & ~vblnk_prev_q;
    x_end    = {1'b0, x_lat_q} + 12'(WIDTH);
    y_end    = {1'b0, y_lat_q} + 12'(HEIGHT);
    h_hit    = (hcount_in >= x_lat_q) & ({1'b0, hcount_in} < x_end);
    v_hit    = (vcount_in >= y_lat_q) & ({1'b0, vcount_in} < y_end);
    // Uses the pre-latch position. Blanking forces this to 0 on a latch
    // cycle anyway.
    in_box_d = alive_lat_q & ~hblnk_in & ~vblnk_in & h_hit & v_hit;
    addr_d   = '0;
    if (in_box_d) begin
      addr_d = {ROW_W'(vcount_in - y_lat_q), COL_W'(hcount_in - x_lat_q)};
    end
    tim_d    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  end

  // Frame latch: only a vblnk rising edge updates the position.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      alive_lat_q  <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (latch_d) begin
        x_lat_q     <= x_in;
        y_lat_q     <= y_in;
        alive_lat_q <= alive;
      end
    end
  end

  // Stages 1 and 2: address issue and alignment with the ROM read.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      in_box_q1 <= 1'b0;
      addr_q    <= '0;
      tim_q1    <= '0;
      rgb_q1    <= '0;
      in_box_q2 <= 1'b0;
      tim_q2    <= '0;
      rgb_q2    <= '0;
    end else begin
      in_box_q1 <= in_box_d;
      addr_q    <= addr_d;
      tim_q1    <= tim_d;
      rgb_q1    <= rgb_in;
      in_box_q2 <= in_box_q1;
      tim_q2    <= tim_q1;
      rgb_q2    <= rgb_q1;
    end
  end

  // Stage 3: composite. The ROM texel for the stage-1 address arrives now.
  always_comb begin
    rgb_d = rgb_q2;
    if (in_box_q2 && (rgb_pixel != TRANSPARENT)) begin
      rgb_d = rgb_pixel;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tim_q3 <= '0;
      rgb_q3 <= '0;
    end else begin
      tim_q3 <= tim_q2;
      rgb_q3 <= rgb_d;
    end
  end

  assign pixel_addr = addr_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_q3;
  assign rgb_out    = rgb_q3;

endmodule
